// File: rtl/i2s_pkg.sv
// Shared I2S constants and the receiver state type; also used by the transmit path.
package i2s_pkg;

    localparam int I2S_SLOT_BITS = 32;
    localparam int MCLK_HALF     = 2;
    localparam int SLOT_W        = $clog2(I2S_SLOT_BITS);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        CAP_L,
        CAP_R
    } i2s_rx_state_t;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S clock divider: mclk = clk/(2*MCLK_HALF), bclk = clk/(2*BCLK_HALF), lrclk toggles every 32 bclk.
// bclk_rise/bclk_fall are one-cycle strobes aligned with the new bclk level; slot_idx and lrclk move with bclk_fall.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int BCLK_HALF = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mclk,
    output logic              bclk,
    output logic              lrclk,
    output logic              bclk_rise,
    output logic              bclk_fall,
    output logic [SLOT_W-1:0] slot_idx
);

    localparam int MC_W = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
    localparam int BC_W = $clog2(BCLK_HALF);

    logic [MC_W-1:0] mclk_cnt;
    logic [BC_W-1:0] bclk_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mclk_cnt  <= '0;
            bclk_cnt  <= '0;
            mclk      <= 1'b0;
            bclk      <= 1'b0;
            lrclk     <= 1'b0;
            bclk_rise <= 1'b0;
            bclk_fall <= 1'b0;
            slot_idx  <= '0;
        end else begin
            bclk_rise <= 1'b0;
            bclk_fall <= 1'b0;

            if (mclk_cnt == MC_W'(MCLK_HALF - 1)) begin
                mclk_cnt <= '0;
                mclk     <= ~mclk;
            end else begin
                mclk_cnt <= mclk_cnt + 1'b1;
            end

            if (bclk_cnt == BC_W'(BCLK_HALF - 1)) begin
                bclk_cnt <= '0;
                bclk     <= ~bclk;
                if (!bclk) begin
                    bclk_rise <= 1'b1;
                end else begin
                    // Slot and word-select change only on the falling edge, as the codec expects.
                    bclk_fall <= 1'b1;
                    slot_idx  <= slot_idx + 1'b1;
                    if (slot_idx == SLOT_W'(I2S_SLOT_BITS - 1)) begin
                        lrclk <= ~lrclk;
                    end
                end
            end else begin
                bclk_cnt <= bclk_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_audio_in.sv
// I2S master receiver: drives codec clocks, deserialises sdata into stereo frames, offers them via valid/ready.
// Capture lags the bclk rising edge by 2 clk (synchroniser); a frame commits 1 clk after the right word latches.
module i2s_audio_in
    import i2s_pkg::*;
#(
    parameter int clk_mhz   = 50,
    parameter int out_res   = 16,
    parameter int BCLK_HALF = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sdata,
    output logic               mclk,
    output logic               bclk,
    output logic               lrclk,
    output logic [out_res-1:0] sample_l,
    output logic [out_res-1:0] sample_r,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               overrun,
    input  logic               clr_overrun
);

    if (out_res < 1 || out_res > 31) begin : g_bad_res
        $error("i2s_audio_in: out_res must be in 1..31");
    end
    if (BCLK_HALF < 4 || (BCLK_HALF % 2) != 0) begin : g_bad_half
        $error("i2s_audio_in: BCLK_HALF must be even and >= 4");
    end
    if (clk_mhz <= 0) begin : g_bad_clk
        $error("i2s_audio_in: clk_mhz must be positive");
    end

    logic              bclk_rise;
    logic              bclk_fall;
    logic [SLOT_W-1:0] slot_idx;

    i2s_clkgen #(
        .BCLK_HALF (BCLK_HALF)
    ) u_clkgen (
        .clk       (clk),
        .rst_n     (rst_n),
        .mclk      (mclk),
        .bclk      (bclk),
        .lrclk     (lrclk),
        .bclk_rise (bclk_rise),
        .bclk_fall (bclk_fall),
        .slot_idx  (slot_idx)
    );

    logic               sync_1;
    logic               sync_2;
    logic               cap_stb;
    i2s_rx_state_t      state;
    logic [out_res-1:0] shift;
    logic [out_res-1:0] shift_nxt;
    logic [out_res-1:0] hold_l;
    logic [out_res-1:0] hold_r;
    logic               commit;
    logic               in_word;
    logic               last_bit;

    // Slot 0 carries the I2S one-bit delay; slots past out_res are padding.
    assign in_word   = (slot_idx != '0) && (slot_idx <= SLOT_W'(out_res));
    assign last_bit  = (slot_idx == SLOT_W'(out_res));
    assign shift_nxt = out_res'({shift, sync_2});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            cap_stb <= 1'b0;
        end else begin
            sync_1  <= sdata;
            sync_2  <= sync_1;
            cap_stb <= bclk_rise;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= WAIT_FRAME;
            shift  <= '0;
            hold_l <= '0;
            hold_r <= '0;
            commit <= 1'b0;
        end else begin
            commit <= 1'b0;

            // A bclk_fall strobe with slot 0 marks the lrclk edge that just happened.
            if (bclk_fall && slot_idx == '0) begin
                case (state)
                    WAIT_FRAME: if (!lrclk) state <= CAP_L;
                    CAP_L:      if (lrclk)  state <= CAP_R;
                    CAP_R:      if (!lrclk) state <= CAP_L;
                    default:    state <= WAIT_FRAME;
                endcase
            end

            if (cap_stb && in_word && state != WAIT_FRAME) begin
                shift <= shift_nxt;
                if (last_bit) begin
                    if (state == CAP_L) begin
                        hold_l <= shift_nxt;
                    end else begin
                        hold_r <= shift_nxt;
                        commit <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_l     <= '0;
            sample_r     <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (commit) begin
                sample_l     <= hold_l;
                sample_r     <= hold_r;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end

            // A new overrun outranks a simultaneous clear.
            if (commit && sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_audio_in.sv
// Bench for i2s_audio_in: codec model drives sdata, a timestamped scoreboard predicts each frame's output.
module tb_i2s_audio_in;

    localparam int RES   = 16;
    localparam int HALF  = 8;
    localparam int FRAME = 64 * 2 * HALF;

    logic           clk;
    logic           rst_n;
    logic           sdata;
    logic           mclk;
    logic           bclk;
    logic           lrclk;
    logic [RES-1:0] sample_l;
    logic [RES-1:0] sample_r;
    logic           sample_valid;
    logic           sample_ready;
    logic           overrun;
    logic           clr_overrun;

    i2s_audio_in #(
        .clk_mhz   (50),
        .out_res   (RES),
        .BCLK_HALF (HALF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sdata        (sdata),
        .mclk         (mclk),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .clr_overrun  (clr_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [RES-1:0] l;
        logic [RES-1:0] r;
        int             due;
    } exp_t;

    exp_t           sbq[$];
    exp_t           e;
    int             n_checks = 0;
    int             n_fail   = 0;
    int             cyc      = 0;

    logic [RES-1:0] cw_l, cw_r, fix_l, fix_r;
    bit             wmode, jmode, cont_mode;
    int             vrise;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic new_words();
        logic [31:0] t;
        if (wmode) begin
            t = $urandom; cw_l = t[RES-1:0];
            t = $urandom; cw_r = t[RES-1:0];
        end else begin
            cw_l = fix_l;
            cw_r = fix_r;
        end
    endtask

    function automatic logic slot_bit(input logic ch, input int s);
        logic [RES-1:0] w;
        w = ch ? cw_r : cw_l;
        if (s >= 1 && s <= RES) return w[RES-s];
        if (jmode) return 1'b1;
        return ($urandom_range(0, 1) != 0);
    endfunction

    // Codec model: new bit after each bclk fall; frame 0 after reset is never delivered.
    int   bslot, frm;
    logic blr, pb_c;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bslot = 0; blr = 1'b0; frm = 0; pb_c = 1'b0;
                sbq.delete();
                new_words();
                sdata = 1'b0;
            end else begin
                if (pb_c && !bclk) begin
                    bslot = (bslot + 1) % 32;
                    if (bslot == 0) begin
                        blr = ~blr;
                        if (!blr) begin
                            frm++;
                            new_words();
                        end
                    end
                    sdata = slot_bit(blr, bslot);
                end
                // Right LSB sampled at this rise: 2 sync + latch + commit edges later it is visible.
                if (!pb_c && bclk && blr && bslot == RES && frm >= 1)
                    sbq.push_back('{l: cw_l, r: cw_r, due: cyc + 3});
                pb_c = bclk;
            end
        end
    end

    // Monitor: handshake reference model plus clock-shape checks.
    logic           mv, mo, r_s, c_s, commit, acc, pv, pm, pb, pl;
    logic [RES-1:0] ml, mr;
    int             lm, lb, ll;
    initial begin
        mv = 0; mo = 0; ml = '0; mr = '0; pv = 0; pm = 0; pb = 0; pl = 0;
        lm = -1; lb = -1; ll = -1;
        forever begin
            @(posedge clk);
            r_s = sample_ready;
            c_s = clr_overrun;
            cyc++;
            if (!rst_n) begin
                mv = 0; mo = 0; ml = '0; mr = '0;
            end else begin
                commit = (sbq.size() > 0) && (sbq[0].due == cyc);
                acc    = mv && r_s;
                if (commit) begin
                    e = sbq.pop_front();
                    if (mv && !acc) mo = 1'b1;
                    else if (c_s)   mo = 1'b0;
                    mv = 1'b1; ml = e.l; mr = e.r;
                end else begin
                    if (acc) mv = 1'b0;
                    if (c_s) mo = 1'b0;
                end
            end
            #1;
            check("valid",   32'(sample_valid), 32'(mv));
            check("left",    32'(sample_l),     32'(ml));
            check("right",   32'(sample_r),     32'(mr));
            check("overrun", 32'(overrun),      32'(mo));
            if (!rst_n) begin
                lm = -1; lb = -1; ll = -1; pm = 0; pb = 0; pl = 0; pv = 0;
            end else begin
                if (mclk != pm) begin
                    if (lm >= 0) check("mclk_half", 32'(cyc - lm), 32'(2));
                    lm = cyc;
                end
                if (bclk != pb) begin
                    if (lb >= 0) check("bclk_half", 32'(cyc - lb), 32'(HALF));
                    lb = cyc;
                end
                if (lrclk != pl) begin
                    if (ll >= 0) check("lrclk_half", 32'(cyc - ll), 32'(FRAME / 2));
                    check("lr_on_bclk_fall", 32'({pb, bclk}), 32'(2'b10));
                    ll = cyc;
                end
                if (sample_valid && !pv) begin
                    if (cont_mode && vrise >= 0) check("valid_period", 32'(cyc - vrise), 32'(FRAME));
                    vrise = cyc;
                end
                pm = mclk; pb = bclk; pl = lrclk; pv = sample_valid;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_mclk"},  32'(mclk),         0);
        check({tag, "_bclk"},  32'(bclk),         0);
        check({tag, "_lrclk"}, 32'(lrclk),        0);
        check({tag, "_l"},     32'(sample_l),     0);
        check({tag, "_r"},     32'(sample_r),     0);
        check({tag, "_valid"}, 32'(sample_valid), 0);
        check({tag, "_ovr"},   32'(overrun),      0);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_push(input string tag);
        int k = 0;
        while (sbq.size() == 0 && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_timeout"}, 32'(sbq.size() == 0), 0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; sdata = 1'b0; sample_ready = 1'b0; clr_overrun = 1'b0;
        wmode = 0; jmode = 0; cont_mode = 0; vrise = -1;
        fix_l = 16'h8001; fix_r = 16'h7FFE;
        run(5);
        #1 check_all_zero("reset");
        rst_n = 1'b1;

        // Fixed words, consumer stalled: one frame held stable, no overrun yet.
        run(2500);
        check("t2_left",  32'(sample_l),     32'h8001);
        check("t2_right", 32'(sample_r),     32'h7FFE);
        check("t2_valid", 32'(sample_valid), 1);
        check("t2_ovr",   32'(overrun),      0);
        sample_ready = 1'b1;
        run(1);
        sample_ready = 1'b0;

        // Zero words with ones in every padding slot.
        fix_l = '0; fix_r = '0; jmode = 1;
        sample_ready = 1'b1;
        run(2 * FRAME);
        check("t6_left",  32'(sample_l), 0);
        check("t6_right", 32'(sample_r), 0);

        // Always-ready: single-cycle valid every frame.
        wmode = 1; jmode = 0; vrise = -1; cont_mode = 1;
        run(5 * FRAME);
        cont_mode = 0;

        // Stall across two commits to force an overrun, then clear it.
        sample_ready = 1'b0;
        run(2 * FRAME + 100);
        check("t4_ovr_set", 32'(overrun), 1);
        wait_push("t4a");
        run(10);
        clr_overrun = 1'b1;
        run(1);
        clr_overrun = 1'b0;
        run(1);
        check("t4_ovr_clr", 32'(overrun), 0);

        // Clear arriving on the same edge as a new overrun must lose.
        wait_push("t4b");
        k = 0;
        while (sbq.size() > 0 && cyc != sbq[0].due - 1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        clr_overrun = 1'b1;
        run(1);
        clr_overrun = 1'b0;
        run(2);
        check("t4_set_wins", 32'(overrun), 1);

        // Random consumer with occasional clears.
        for (int i = 0; i < 6 * FRAME; i++) begin
            sample_ready = ($urandom_range(0, 1) != 0);
            clr_overrun  = ($urandom_range(0, 31) == 0);
            @(negedge clk);
        end
        clr_overrun = 1'b0;

        // Reset mid-frame: outputs clear at once; frame 0 after release is dropped.
        run(300);
        rst_n = 1'b0;
        #1 check_all_zero("midrst");
        run(3);
        rst_n = 1'b1;
        sample_ready = 1'b1;
        k = 0;
        while (!sample_valid && k < 3 * FRAME) begin
            @(negedge clk);
            k++;
        end
        // Frame 1 right LSB rises at edge 8 + 16*112; three more edges to valid.
        check("first_valid_after_reset", 32'(k), 32'(1803));

        for (int i = 0; i < 3 * FRAME; i++) begin
            sample_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
